// File: rtl/nib_pkg.sv
// Shared definitions for the nibble packer and the nibble-maximum selector.
package nib_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int WORD_W  = 16;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 3;

    // FULL means one completed word is parked in the assembly register.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } pack_state_t;

    function automatic logic [NIB_W-1:0] nib_slice(input logic [WORD_W-1:0] word,
                                                   input logic [ID_W-1:0]   id);
        return word[{id, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/nib_word_reg.sv
// Output holding register with a valid/ready handshake: load sets valid, consume clears it.
module nib_word_reg
    import nib_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              ready,
    output logic [WORD_W-1:0] word,
    output logic [CNT_W-1:0]  cnt,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            word  <= load_word;
            cnt   <= load_cnt;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nib_pack.sv
// Packs a valid/ready nibble stream into 16-bit words, padding partial words on flush.
module nib_pack
    import nib_pkg::*;
#(
    parameter logic [NIB_W-1:0] PAD = 4'h0
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic [NIB_W-1:0]  NIB_IN,
    input  logic              NIB_VALID,
    output logic              NIB_READY,
    input  logic              FLUSH,
    output logic [WORD_W-1:0] NIBBLES,
    output logic              WORD_VALID,
    input  logic              WORD_READY,
    output logic [CNT_W-1:0]  WORD_CNT
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NIB);

    pack_state_t       state;
    logic [WORD_W-1:0] asm_q, asm_d, merged, padded, load_word;
    logic [CNT_W-1:0]  asm_cnt, asm_cnt_d, held_cnt, held_cnt_d, post_cnt, load_cnt;
    logic              accept, slot_free, complete, load;

    always_comb begin
        state     = (asm_cnt == CNT_FULL) ? ST_FULL : ST_FILL;
        NIB_READY = (state == ST_FILL);
        accept    = NIB_VALID && NIB_READY;
        slot_free = !WORD_VALID || WORD_READY;
        post_cnt  = asm_cnt + CNT_W'(accept);

        merged = asm_q;
        if (accept) begin
            merged[{asm_cnt[ID_W-1:0], 2'b00} +: NIB_W] = NIB_IN;
        end

        // Positions at or beyond the real count take the pad value.
        padded = '0;
        for (int i = 0; i < NUM_NIB; i++) begin
            padded[i*NIB_W +: NIB_W] = (CNT_W'(i) < post_cnt) ? nib_slice(merged, ID_W'(i)) : PAD;
        end

        complete = (state == ST_FILL) &&
                   ((post_cnt == CNT_FULL) || (FLUSH && (post_cnt != '0)));
    end

    always_comb begin
        asm_d      = merged;
        asm_cnt_d  = post_cnt;
        held_cnt_d = held_cnt;
        load       = 1'b0;
        load_word  = padded;
        load_cnt   = post_cnt;

        if (state == ST_FULL) begin
            asm_d = asm_q;
            if (slot_free) begin
                load      = 1'b1;
                load_word = asm_q;
                load_cnt  = held_cnt;
                asm_cnt_d = '0;
            end
        end else if (complete) begin
            if (slot_free) begin
                load      = 1'b1;
                asm_cnt_d = '0;
            end else begin
                asm_d      = padded;
                held_cnt_d = post_cnt;
                asm_cnt_d  = CNT_FULL;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            asm_q    <= '0;
            asm_cnt  <= '0;
            held_cnt <= '0;
        end else begin
            asm_q    <= asm_d;
            asm_cnt  <= asm_cnt_d;
            held_cnt <= held_cnt_d;
        end
    end

    nib_word_reg u_word_reg (
        .clk       (CLK),
        .rst_n     (RESET_L),
        .load      (load),
        .load_word (load_word),
        .load_cnt  (load_cnt),
        .ready     (WORD_READY),
        .word      (NIBBLES),
        .cnt       (WORD_CNT),
        .valid     (WORD_VALID)
    );

endmodule

// File: tb/tb_nib_pack.sv
// Self-checking bench for nib_pack: queue-based word model plus directed literal checks.
module tb_nib_pack;

    localparam logic [3:0] TB_PAD = 4'hF;

    logic        CLK;
    logic        RESET_L;
    logic [3:0]  NIB_IN;
    logic        NIB_VALID;
    logic        NIB_READY;
    logic        FLUSH;
    logic [15:0] NIBBLES;
    logic        WORD_VALID;
    logic        WORD_READY;
    logic [2:0]  WORD_CNT;

    int pass_count  = 0;
    int total_count = 0;
    bit check_en    = 0;

    typedef struct {
        logic [15:0] w;
        logic [2:0]  c;
    } word_t;

    logic [3:0] cur_q[$];
    word_t      exp_q[$];
    bit         model_ready;
    word_t      model_word;

    nib_pack #(.PAD(TB_PAD)) dut (
        .CLK        (CLK),
        .RESET_L    (RESET_L),
        .NIB_IN     (NIB_IN),
        .NIB_VALID  (NIB_VALID),
        .NIB_READY  (NIB_READY),
        .FLUSH      (FLUSH),
        .NIBBLES    (NIBBLES),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .WORD_CNT   (WORD_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] n, input logic f, input logic wr);
        @(negedge CLK);
        NIB_VALID  = v;
        NIB_IN     = n;
        FLUSH      = f;
        WORD_READY = wr;
    endtask

    // Model: completed-but-unconsumed words sit in exp_q; the packer can hold at most two.
    always @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            cur_q.delete();
            exp_q.delete();
        end else begin
            model_ready = (exp_q.size() < 2);
            if (WORD_READY && exp_q.size() > 0) void'(exp_q.pop_front());
            if (NIB_VALID && model_ready) cur_q.push_back(NIB_IN);
            if (cur_q.size() == 4 || (FLUSH && cur_q.size() > 0)) begin
                model_word.w = {4{TB_PAD}};
                for (int i = 0; i < cur_q.size(); i++) model_word.w[4*i +: 4] = cur_q[i];
                model_word.c = 3'(cur_q.size());
                cur_q.delete();
                exp_q.push_back(model_word);
            end
        end
    end

    always @(negedge CLK) begin
        if (RESET_L && check_en) begin
            checkOutput("model word_valid", WORD_VALID, 16'(exp_q.size() > 0));
            checkOutput("model nib_ready", NIB_READY, 16'(exp_q.size() < 2));
            if (exp_q.size() > 0) begin
                checkOutput("model nibbles", NIBBLES, exp_q[0].w);
                checkOutput("model word_cnt", WORD_CNT, 16'(exp_q[0].c));
            end
        end
    end

    initial begin
        RESET_L    = 1'b0;
        NIB_IN     = '0;
        NIB_VALID  = 1'b0;
        FLUSH      = 1'b0;
        WORD_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset word_valid", WORD_VALID, 16'h0);
        checkOutput("reset nibbles", NIBBLES, 16'h0000);
        checkOutput("reset word_cnt", WORD_CNT, 16'h0);
        RESET_L  = 1'b1;
        check_en = 1'b1;
        applyStimulus(0, 0, 0, 1);
        checkOutput("post-reset nib_ready", NIB_READY, 16'h1);

        // Four nibbles, word visible after the 4th accept edge.
        for (int i = 1; i <= 4; i++) applyStimulus(1, 4'(i), 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("first word valid", WORD_VALID, 16'h1);
        checkOutput("first word", NIBBLES, 16'h4321);
        checkOutput("first word cnt", WORD_CNT, 16'h4);
        applyStimulus(0, 0, 0, 1);

        // Back-to-back stream at full throughput.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 4'(i), 0, 1);
            checkOutput("stream nib_ready", NIB_READY, 16'h1);
            if (i == 4) checkOutput("stream word0", NIBBLES, 16'h3210);
            if (i == 8) checkOutput("stream word1", NIBBLES, 16'h7654);
        end
        applyStimulus(0, 0, 0, 1);
        checkOutput("stream word2", NIBBLES, 16'hBA98);
        applyStimulus(0, 0, 0, 1);

        // Stalled downstream: one word out, one held, then back-pressure.
        for (int i = 0; i < 8; i++) applyStimulus(1, 4'(i), 0, 0);
        applyStimulus(1, 8, 0, 0);
        checkOutput("stall nib_ready", NIB_READY, 16'h0);
        checkOutput("stall word", NIBBLES, 16'h3210);
        applyStimulus(1, 8, 0, 0);
        applyStimulus(1, 8, 0, 0);
        checkOutput("stall still blocked", NIB_READY, 16'h0);
        checkOutput("stall word stable", NIBBLES, 16'h3210);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("held word out", NIBBLES, 16'h7654);
        checkOutput("ready after transfer", NIB_READY, 16'h1);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);

        // Flush with a same-cycle nibble, then flush with nothing assembled.
        applyStimulus(1, 4'hA, 0, 1);
        applyStimulus(1, 4'hB, 0, 1);
        applyStimulus(1, 4'hC, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("flush word", NIBBLES, 16'hFCBA);
        checkOutput("flush cnt", WORD_CNT, 16'h3);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("empty flush no word", WORD_VALID, 16'h0);

        // Asynchronous reset while FULL.
        for (int i = 1; i <= 8; i++) applyStimulus(1, 4'(i), 0, 0);
        applyStimulus(0, 0, 0, 0);
        #2 RESET_L = 1'b0;
        #1;
        checkOutput("reset full valid", WORD_VALID, 16'h0);
        checkOutput("reset full nibbles", NIBBLES, 16'h0000);
        checkOutput("reset full cnt", WORD_CNT, 16'h0);
        checkOutput("reset full ready", NIB_READY, 16'h1);
        @(negedge CLK);
        RESET_L = 1'b1;

        // Asynchronous reset mid-word, then a clean word.
        applyStimulus(1, 4'h9, 0, 1);
        applyStimulus(1, 4'h9, 0, 1);
        applyStimulus(0, 0, 0, 1);
        #2 RESET_L = 1'b0;
        @(negedge CLK);
        RESET_L = 1'b1;
        for (int i = 5; i <= 8; i++) applyStimulus(1, 4'(i), 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("after reset word", NIBBLES, 16'h8765);
        checkOutput("after reset cnt", WORD_CNT, 16'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/nib_pack.md
# nib_pack

Nibble-stream packer that produces the 16-bit `NIBBLES` word consumed by the nibble-maximum selector (`nm2`). It accepts 4-bit nibbles one per cycle under a valid/ready handshake, assembles four of them into a word, and presents the word with valid/ready flow control. The block is the upstream writer for the selector's input, replacing the free-running stimulus generator in system builds. A flush input closes a partial word by padding it.

## Interface

Parameters:
- `PAD` — default 4'h0 — value written into unfilled nibble positions on flush.

Ports:
- Clocking: single clock `CLK`; reset `RESET_L` is asynchronous, active-low.
- `CLK` input 1 — single clock; all state updates on rising edge.
- `RESET_L` input 1 — asynchronous reset, active-low.
- `NIB_IN` input 4 — incoming nibble.
- `NIB_VALID` input 1 — `NIB_IN` valid.
- `NIB_READY` output 1 — block can accept a nibble this cycle.
- `FLUSH` input 1 — close the current partial word.
- `NIBBLES` output 16 — assembled word; nibble i (ID i) at `[4i+3:4i]`.
- `WORD_VALID` output 1 — `NIBBLES` holds an unconsumed word.
- `WORD_READY` input 1 — downstream accepts the word.
- `WORD_CNT` output 3 — number of real nibbles in `NIBBLES`, 1..4; the rest are `PAD`.

## Operation

- Internal state: assembly register `asm[15:0]`, `asm_cnt` (0..4), output register (`NIBBLES`, `WORD_CNT`, `WORD_VALID`).
- Nibble accept: `NIB_VALID && NIB_READY`. The nibble is written to position `asm_cnt`; then `asm_cnt` increments. The first nibble of a word is ID 0.
- `NIB_READY = (asm_cnt != 4)`, independent of `NIB_VALID`.
- Output slot free this cycle: `!WORD_VALID || WORD_READY`.
- Word completes when `asm_cnt` would reach 4, or on a flush with a post-accept count of 1..3 (positions ≥ count filled with `PAD`).
- Completed word with free slot: load the output register, set `WORD_VALID`, and set `asm_cnt` to 0 on the same edge.
- Completed word with slot busy: hold in `asm` and set `asm_cnt` to 4 (FULL). `WORD_CNT` for a held word is latched as the real count.
- FULL state: when the slot frees, transfer on that edge and set `asm_cnt` to 0. No nibbles are accepted while FULL.
- `FLUSH` together with an accept: include the nibble first, then pad.
- `FLUSH` with post-accept count 0: ignored, no word produced.
- `FLUSH` in FULL: ignored.
- Output handshake:
  - `WORD_VALID && WORD_READY` consumes the word. `WORD_VALID` clears unless a new word loads on the same edge.
  - `NIBBLES` and `WORD_CNT` are stable while `WORD_VALID` is high and `WORD_READY` is low.
- States, derived from `asm_cnt`:
  - FILL (0..3) → FULL on a completed word with busy slot.
  - FULL → FILL(0) when the slot frees.

## Timing

- Reset values: `NIBBLES` 16'h0000, `WORD_CNT` 0, `WORD_VALID` 0, `asm_cnt` 0, `NIB_READY` 1 once reset deasserts.
- Reset mid-word or mid-hold discards all data. No output is glitched beyond the asynchronous clear.
- Latency: a 4th-nibble accept at edge k with a free slot gives `WORD_VALID` high after edge k.
- Throughput: with `WORD_READY` held at 1, one word every 4 cycles with no bubbles.
- With a stalled slot, exactly one extra word is buffered (in `asm`). `NIB_READY` drops the cycle after that word completes.
- Transfer from FULL happens on the same edge as the downstream consume. `NIB_READY` rises the cycle after.

## Structure

- Shared package `nib_pkg`:
  - `NIB_W=4`, `NUM_NIB=4`, `WORD_W=16`, `ID_W=2`, `CNT_W=3`.
  - Nibble-slice helper function; shared with `nm2`.
- One natural sub-module, `nib_word_reg`: the output holding register with valid/ready, load, and consume. Top level holds `asm`, `asm_cnt`, and the pad/flush logic.
- Single file per module. No memories.

## Test plan

- Reset, then nibbles 1,2,3,4 on consecutive cycles with `WORD_READY`=1: `NIBBLES`=16'h4321, `WORD_CNT`=4, `WORD_VALID` high one cycle after the 4th accept.
- 12 nibbles back-to-back (0..B) with `WORD_READY`=1: words 16'h3210, 16'h7654, 16'hBA98 on consecutive 4-cycle boundaries; `NIB_READY` never low.
- `WORD_READY`=0 and 8 nibbles offered: first word in the output register, second held. `NIB_READY` goes low after the 8th accept and the 9th nibble is stalled. Raise `WORD_READY`: words appear in order, then `NIB_READY`=1.
- Nibbles A,B then `FLUSH` with nibble C in the same cycle, `PAD`=4'hF: `NIBBLES`=16'hFCBA, `WORD_CNT`=3. `FLUSH` with empty assembly produces no word.
- `RESET_L` asserted asynchronously mid-word (2 nibbles in) and while FULL: outputs clear immediately. Next 4 nibbles 5,6,7,8 give 16'h8765.
- Connect to `nm2` with nibbles 3,9,1,9: the selector reports `NIBBLE_MAYOR`=9 with the ID per its tie rule, confirming ID 0 = first nibble.
